ws2811_serial_tx: RTL and testbench

- Transmit-side engine of the WS2811 LED chain.
- Pulls 24-bit colour words from the rgb wave provider and serialises them onto the single-wire WS2811 data line.
- Drives the provider's `advance` and `serial_reset` inputs, so it owns frame timing: LED_COUNT words, then a latch gap.
- Sits between the rgb wave provider and the FPGA output pin driving the strip.

---
 rtl/ws2811_pkg.sv | 38 +++
 rtl/ws2811_serial_tx_bit_encoder.sv | 35 +++
 rtl/ws2811_serial_tx.sv | 208 ++++++++++++++++++++
 tb/tb_ws2811_serial_tx.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2811_pkg.sv
// ws2811_pkg: shared definitions for the WS2811 LED chain (transmit engine,
// rgb wave provider and benches). Holds the FSM state encoding, the colour
// word width, the default 50 MHz timing constants and the colour-order helper.
package ws2811_pkg;

  // Colour word width: 8 bits each of three channels
  localparam int WORD_BITS        = 24;

  // Default frame and timing constants for a 50 MHz system clock
  localparam int LED_COUNT_DEF    = 200;
  localparam int BIT_CYCLES_DEF   = 62;    // 1.24 us per data bit
  localparam int T0H_CYCLES_DEF   = 20;    // 0.40 us high for a '0'
  localparam int T1H_CYCLES_DEF   = 40;    // 0.80 us high for a '1'
  localparam int RESET_CYCLES_DEF = 2600;  // 52 us latch gap

  // Transmit engine states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_LATCH = 2'd2
  } tx_state_e;

  // Reorders a provider word into wire order; grb_en swaps the top two bytes
  // so green leaves first, as native GRB parts expect.
  function automatic logic [WORD_BITS-1:0] order_word(
    input logic [WORD_BITS-1:0] rgb,
    input logic                 grb_en
  );
    logic [WORD_BITS-1:0] word_s;
    if (grb_en) begin
      word_s = {rgb[15:8], rgb[23:16], rgb[7:0]};
    end else begin
      word_s = rgb;
    end
    return word_s;
  endfunction

endpackage

// File: rtl/ws2811_serial_tx_bit_encoder.sv
// ws2811_bit_encoder: turns the bit value and the position inside the bit
// period into the WS2811 line level. The inputs describe the cycle that is
// about to start, so the registered output lines up with the counters that
// the top module updates on the same edge.
module ws2811_bit_encoder
  import ws2811_pkg::*;
#(
  parameter int CYC_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             active,
  input  logic             bit_val,
  input  logic [CYC_W-1:0] cyc_cnt,
  input  logic [CYC_W-1:0] t0h,
  input  logic [CYC_W-1:0] t1h,
  output logic             dout
);

  logic dout_r;

  // Registered line level: high for the first T0H/T1H cycles of a bit, low otherwise
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dout_r <= 1'b0;
    end else if (active) begin
      dout_r <= (cyc_cnt < (bit_val ? t1h : t0h));
    end else begin
      dout_r <= 1'b0;
    end
  end

  assign dout = dout_r;

endmodule

// File: rtl/ws2811_serial_tx.sv
// ws2811_serial_tx: WS2811 transmit engine. Pulls LED_COUNT colour words per
// frame from the rgb wave provider (one advance pulse per word), serialises
// them MSB first with WS2811 pulse-width coding, then holds the line low for
// the latch gap while serial_reset rewinds the provider.
// Build option: define WS2811_GRB_ORDER_EN to send green first (GRB parts);
// otherwise rgb[23] is the first bit on the wire.
module ws2811_serial_tx
  import ws2811_pkg::*;
#(
  parameter int LED_COUNT    = LED_COUNT_DEF,
  parameter int BIT_CYCLES   = BIT_CYCLES_DEF,
  parameter int T0H_CYCLES   = T0H_CYCLES_DEF,
  parameter int T1H_CYCLES   = T1H_CYCLES_DEF,
  parameter int RESET_CYCLES = RESET_CYCLES_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [WORD_BITS-1:0] rgb,
  output logic                 advance,
  output logic                 serial_reset,
  output logic                 dout,
  output logic                 busy,
  output logic                 frame_done
);

  // Counter widths sized so that every terminal value fits without wrapping
  localparam int CYC_W = $clog2(BIT_CYCLES + 1);
  localparam int BIT_W = $clog2(WORD_BITS + 1);
  localparam int LED_W = $clog2(LED_COUNT + 1);
  localparam int GAP_W = $clog2(RESET_CYCLES + 1);

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_BITS - 1);
  localparam logic [LED_W-1:0] LED_LAST = LED_W'(LED_COUNT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(RESET_CYCLES - 1);
  localparam logic [CYC_W-1:0] T0H_THR  = CYC_W'(T0H_CYCLES);
  localparam logic [CYC_W-1:0] T1H_THR  = CYC_W'(T1H_CYCLES);

`ifdef WS2811_GRB_ORDER_EN
  localparam logic GRB_EN = 1'b1;
`else
  localparam logic GRB_EN = 1'b0;
`endif

  tx_state_e            state_r;
  logic [WORD_BITS-1:0] shreg_r;
  logic [BIT_W-1:0]     bit_cnt_r;
  logic [CYC_W-1:0]     cyc_cnt_r;
  logic [LED_W-1:0]     led_cnt_r;
  logic [GAP_W-1:0]     gap_cnt_r;
  logic                 advance_r;
  logic                 serial_reset_r;
  logic                 busy_r;
  logic                 frame_done_r;

  logic [WORD_BITS-1:0] load_word_s;
  logic                 bit_end_s;
  logic                 word_end_s;
  logic                 last_led_s;
  logic                 gap_end_s;
  logic                 load_s;
  logic                 send_nxt_s;
  logic                 bit_nxt_s;
  logic [CYC_W-1:0]     cyc_nxt_s;

  // Event decode plus a look-ahead of the bit and cycle that start on the next edge
  always_comb begin
    load_word_s = order_word(rgb, GRB_EN);
    bit_end_s   = (state_r == ST_SEND) && (cyc_cnt_r == CYC_LAST);
    word_end_s  = bit_end_s && (bit_cnt_r == BIT_LAST);
    last_led_s  = (led_cnt_r == LED_LAST);
    gap_end_s   = (state_r == ST_LATCH) && (gap_cnt_r == GAP_LAST);
    load_s      = ((state_r == ST_IDLE) && enable) ||
                  (gap_end_s && enable) ||
                  (word_end_s && !last_led_s);

    send_nxt_s  = 1'b0;
    bit_nxt_s   = 1'b0;
    cyc_nxt_s   = {CYC_W{1'b0}};
    if (load_s) begin
      send_nxt_s = 1'b1;
      bit_nxt_s  = load_word_s[WORD_BITS-1];
      cyc_nxt_s  = {CYC_W{1'b0}};
    end else if ((state_r == ST_SEND) && !word_end_s) begin
      send_nxt_s = 1'b1;
      if (bit_end_s) begin
        bit_nxt_s = shreg_r[WORD_BITS-2];
        cyc_nxt_s = {CYC_W{1'b0}};
      end else begin
        bit_nxt_s = shreg_r[WORD_BITS-1];
        cyc_nxt_s = cyc_cnt_r + CYC_W'(1);
      end
    end else begin
      send_nxt_s = 1'b0;
      bit_nxt_s  = 1'b0;
      cyc_nxt_s  = {CYC_W{1'b0}};
    end
  end

  // Frame FSM: word loading, bit/LED/gap counting and registered handshake outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r        <= ST_IDLE;
      shreg_r        <= {WORD_BITS{1'b0}};
      bit_cnt_r      <= {BIT_W{1'b0}};
      cyc_cnt_r      <= {CYC_W{1'b0}};
      led_cnt_r      <= {LED_W{1'b0}};
      gap_cnt_r      <= {GAP_W{1'b0}};
      advance_r      <= 1'b0;
      serial_reset_r <= 1'b0;
      busy_r         <= 1'b0;
      frame_done_r   <= 1'b0;
    end else begin
      advance_r <= load_s;
      case (state_r)
        ST_IDLE: begin
          frame_done_r   <= 1'b0;
          serial_reset_r <= 1'b0;
          if (enable) begin
            shreg_r   <= load_word_s;
            bit_cnt_r <= {BIT_W{1'b0}};
            cyc_cnt_r <= {CYC_W{1'b0}};
            led_cnt_r <= {LED_W{1'b0}};
            busy_r    <= 1'b1;
            state_r   <= ST_SEND;
          end else begin
            busy_r    <= 1'b0;
          end
        end

        ST_SEND: begin
          if (word_end_s) begin
            if (!last_led_s) begin
              // Next LED follows with no gap
              shreg_r   <= load_word_s;
              bit_cnt_r <= {BIT_W{1'b0}};
              cyc_cnt_r <= {CYC_W{1'b0}};
              led_cnt_r <= led_cnt_r + LED_W'(1);
            end else begin
              cyc_cnt_r      <= {CYC_W{1'b0}};
              bit_cnt_r      <= {BIT_W{1'b0}};
              gap_cnt_r      <= {GAP_W{1'b0}};
              serial_reset_r <= 1'b1;
              frame_done_r   <= (GAP_LAST == {GAP_W{1'b0}});
              state_r        <= ST_LATCH;
            end
          end else if (bit_end_s) begin
            shreg_r   <= {shreg_r[WORD_BITS-2:0], 1'b0};
            bit_cnt_r <= bit_cnt_r + BIT_W'(1);
            cyc_cnt_r <= {CYC_W{1'b0}};
          end else begin
            cyc_cnt_r <= cyc_cnt_r + CYC_W'(1);
          end
        end

        ST_LATCH: begin
          if (gap_end_s) begin
            serial_reset_r <= 1'b0;
            frame_done_r   <= 1'b0;
            gap_cnt_r      <= {GAP_W{1'b0}};
            if (enable) begin
              // Back-to-back frame: reload exactly as from IDLE
              shreg_r   <= load_word_s;
              bit_cnt_r <= {BIT_W{1'b0}};
              cyc_cnt_r <= {CYC_W{1'b0}};
              led_cnt_r <= {LED_W{1'b0}};
              busy_r    <= 1'b1;
              state_r   <= ST_SEND;
            end else begin
              busy_r    <= 1'b0;
              state_r   <= ST_IDLE;
            end
          end else begin
            gap_cnt_r    <= gap_cnt_r + GAP_W'(1);
            frame_done_r <= ((gap_cnt_r + GAP_W'(1)) == GAP_LAST);
          end
        end

        default: begin
          state_r        <= ST_IDLE;
          serial_reset_r <= 1'b0;
          frame_done_r   <= 1'b0;
          busy_r         <= 1'b0;
        end
      endcase
    end
  end

  ws2811_bit_encoder #(
    .CYC_W (CYC_W)
  ) u_bit_encoder (
    .clock   (clock),
    .reset   (reset),
    .active  (send_nxt_s),
    .bit_val (bit_nxt_s),
    .cyc_cnt (cyc_nxt_s),
    .t0h     (T0H_THR),
    .t1h     (T1H_THR),
    .dout    (dout)
  );

  assign advance      = advance_r;
  assign serial_reset = serial_reset_r;
  assign busy         = busy_r;
  assign frame_done   = frame_done_r;

endmodule

// File: tb/tb_ws2811_serial_tx.sv
// tb_ws2811_serial_tx: scoreboard bench for ws2811_serial_tx. A provider
// process serves random colour words, pushing each frame's wire-order words
// when the frame starts; a monitor decodes the dout waveform back into words
// and checks bit timing, advance spacing, latch gap and frame_done placement.
module tb_ws2811_serial_tx;

  localparam int LEDS  = 3;
  localparam int BITC  = 62;
  localparam int T0H   = 20;
  localparam int T1H   = 40;
  localparam int RSTC  = 2600;
  localparam int WBITS = 24;
  localparam int GARB  = 1400;   // cycles of junk on rgb after each advance

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [23:0] rgb = 24'h0;
  logic        advance, serial_reset, dout, busy, frame_done;

  int n_checks = 0;
  int n_fail = 0;
  int adv_total = 0;
  int frames_done = 0;
  int words_seen = 0;

  logic [23:0] exp_q[$];
  logic [23:0] frame_words [LEDS];

  always #5 clock = ~clock;

  ws2811_serial_tx #(
    .LED_COUNT    (LEDS),
    .BIT_CYCLES   (BITC),
    .T0H_CYCLES   (T0H),
    .T1H_CYCLES   (T1H),
    .RESET_CYCLES (RSTC)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .rgb          (rgb),
    .advance      (advance),
    .serial_reset (serial_reset),
    .dout         (dout),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Order in which the bits of a provider word appear on the wire
  function automatic logic [23:0] wire_order(input logic [23:0] w);
`ifdef WS2811_GRB_ORDER_EN
    return {w[15:8], w[23:16], w[7:0]};
`else
    return w;
`endif
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames_done < target && n < 9000) begin
      step();
      n++;
    end
    check(frames_done >= target, "frame_timeout", frames_done, target);
  endtask

  task automatic wait_adv(input int target);
    int n = 0;
    while (adv_total < target && n < 4000) begin
      step();
      n++;
    end
    check(adv_total >= target, "advance_timeout", adv_total, target);
  endtask

  // Provider: steps on advance, rewinds on serial_reset, junk between load instants
  initial begin : provider
    int idx;
    int gcnt;
    logic sr_q;
    idx = 0;
    gcnt = 0;
    sr_q = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        idx = 0;
        gcnt = 0;
        sr_q = 1'b0;
        exp_q.delete();
      end else begin
        if (serial_reset && !sr_q) begin
          for (int i = 0; i < LEDS; i++) frame_words[i] = 24'($urandom);
          idx = 0;
          gcnt = 0;
        end else if (advance) begin
          if (idx == 0) begin
            for (int i = 0; i < LEDS; i++) exp_q.push_back(wire_order(frame_words[i]));
          end
          if (idx < LEDS) idx++;
          gcnt = GARB;
          adv_total++;
        end else if (gcnt > 0) begin
          gcnt--;
        end
        sr_q = serial_reset;
      end
      rgb = (gcnt > 0 || idx >= LEDS) ? 24'($urandom) : frame_words[idx];
    end
  end

  // Monitor: decodes dout into words and checks frame timing
  initial begin : monitor
    int cyc, rise_cyc, hi_len, bits_in_frame, bits_in_word;
    int adv_in_frame, last_adv, sr_len, saw_done;
    logic dout_q, sr_q, en_q, lat_bad;
    logic [23:0] acc, exp_w;
    cyc = 0; rise_cyc = 0; hi_len = 0; bits_in_frame = 0; bits_in_word = 0;
    adv_in_frame = 0; last_adv = 0; sr_len = 0; saw_done = 0;
    dout_q = 1'b0; sr_q = 1'b0; en_q = 1'b0; lat_bad = 1'b0; acc = 24'h0;
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset) begin
        hi_len = 0; bits_in_frame = 0; bits_in_word = 0; adv_in_frame = 0;
        sr_len = 0; saw_done = 0; lat_bad = 1'b0; acc = 24'h0;
        dout_q = 1'b0; sr_q = 1'b0;
      end else begin
        // Latch gap
        if (serial_reset && !sr_q) begin
          check(bits_in_frame == LEDS * WBITS, "frame_bits", bits_in_frame, LEDS * WBITS);
          check(adv_in_frame == LEDS, "frame_advances", adv_in_frame, LEDS);
          check(cyc - rise_cyc == BITC, "last_bit_len", cyc - rise_cyc, BITC);
          sr_len = 0; saw_done = 0; lat_bad = 1'b0;
        end
        if (serial_reset) begin
          sr_len++;
          if (dout) lat_bad = 1'b1;
        end
        if (frame_done) begin
          check(serial_reset && sr_len == RSTC, "done_position", sr_len, RSTC);
          saw_done++;
        end
        if (!serial_reset && sr_q) begin
          check(sr_len == RSTC, "latch_len", sr_len, RSTC);
          check(saw_done == 1, "done_count", saw_done, 1);
          check(!lat_bad, "latch_dout_low", lat_bad, 0);
          if (en_q) check(advance && dout && busy, "b2b_restart", {advance, dout, busy}, 3'b111);
          else check(!advance && !dout && !busy, "to_idle", {advance, dout, busy}, 3'b000);
          frames_done++;
          bits_in_frame = 0; bits_in_word = 0; adv_in_frame = 0;
        end
        if (dout || serial_reset) check(busy, "busy", busy, 1);
        // Bit decoding
        if (dout && !dout_q) begin
          if (bits_in_frame > 0) check(cyc - rise_cyc == BITC, "bit_period", cyc - rise_cyc, BITC);
          rise_cyc = cyc;
          hi_len = 1;
        end else if (dout) begin
          hi_len++;
        end
        if (!dout && dout_q) begin
          check(hi_len == T0H || hi_len == T1H, "high_time", hi_len, (hi_len > (T0H + T1H) / 2) ? T1H : T0H);
          acc = {acc[22:0], (hi_len > (T0H + T1H) / 2)};
          bits_in_word++;
          bits_in_frame++;
          if (bits_in_word == WBITS) begin
            bits_in_word = 0;
            words_seen++;
            if (exp_q.size() == 0) begin
              check(1'b0, "word_unexpected", acc, 0);
            end else begin
              exp_w = exp_q.pop_front();
              check(acc == exp_w, "word", acc, exp_w);
            end
          end
        end
        // Advance handshake
        if (advance) begin
          check(!serial_reset && dout, "advance_timing", {serial_reset, dout}, 2'b01);
          if (adv_in_frame > 0) check(cyc - last_adv == WBITS * BITC, "advance_spacing", cyc - last_adv, WBITS * BITC);
          last_adv = cyc;
          adv_in_frame++;
        end
        dout_q = dout;
        sr_q = serial_reset;
      end
      en_q = enable;
    end
  end

  // Directed sequence
  initial begin : stimulus
    int base;
    int n;
    frame_words[0] = 24'hA5_0F_F0;
    frame_words[1] = 24'hFF_00_00;
    frame_words[2] = 24'($urandom);
    reset = 1'b0;
    enable = 1'b0;
    repeat (3) step();
    check({dout, advance, serial_reset, busy, frame_done} == 5'b0, "reset_state",
          {dout, advance, serial_reset, busy, frame_done}, 0);
    reset = 1'b1;
    repeat (4) step();
    check({dout, busy} == 2'b00, "idle_quiet", {dout, busy}, 0);

    // Enable latency: dout high one cycle after enable is sampled
    enable = 1'b1;
    #2;
    check(dout == 1'b0, "pre_enable_dout", dout, 0);
    step();
    check({dout, advance, busy, serial_reset} == 4'b1110, "enable_latency",
          {dout, advance, busy, serial_reset}, 4'b1110);

    // Two back-to-back frames, then drop enable at bit 5 of LED 0 of the third
    wait_frames(1);
    wait_frames(2);
    repeat (5 * BITC) step();
    enable = 1'b0;
    wait_frames(3);
    repeat (5) step();
    check({busy, dout, serial_reset} == 3'b000, "idle_after_drop", {busy, dout, serial_reset}, 0);

    // Asynchronous reset while dout is high inside LED 1
    base = adv_total;
    enable = 1'b1;
    wait_adv(base + 2);
    repeat (100) step();
    n = 0;
    while (!dout && n < BITC) begin
      step();
      n++;
    end
    check(dout == 1'b1, "mid_bit_high", dout, 1);
    #2;
    reset = 1'b0;
    #1;
    check({dout, advance, serial_reset, busy, frame_done} == 5'b0, "async_reset",
          {dout, advance, serial_reset, busy, frame_done}, 0);
    repeat (3) step();
    reset = 1'b1;
    step();
    check({dout, advance, busy} == 3'b111, "restart", {dout, advance, busy}, 3'b111);
    repeat (10) step();
    enable = 1'b0;
    wait_frames(4);
    repeat (5) step();
    check(busy == 1'b0, "final_idle", busy, 0);

    check(exp_q.size() == 0, "queue_empty", exp_q.size(), 0);
    check(frames_done == 4, "frame_count", frames_done, 4);
    check(words_seen >= 4 * LEDS, "words_seen", words_seen, 4 * LEDS);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
